interrupt_controller: RTL and testbench

// Collects interrupt lines from IO peripherals (timer, UART, SPI, ...) and drives a

---
 rtl/interrupt_controller.sv | 120 ++++++++++++
 tb/tb_interrupt_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises peripheral interrupt lines, latches them as pending
// (level or rising-edge per line), masks them and drives one registered request to the core.
module interrupt_controller #(
   parameter int unsigned BASE_ADDRESS   = 0,
   parameter int unsigned NUM_INTERRUPTS = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      write_en_i,
   input  logic                      read_en_i,
   input  logic [31:0]               address_i,
   input  logic [31:0]               write_data_i,
   output logic [31:0]               read_data_o,
   input  logic [NUM_INTERRUPTS-1:0] irq_in_i,
   output logic                      irq_out_o
);

   localparam int unsigned N = NUM_INTERRUPTS;

   localparam logic [31:0] ADDR_PENDING = 32'(BASE_ADDRESS);
   localparam logic [31:0] ADDR_MASK    = 32'(BASE_ADDRESS) + 32'h04;
   localparam logic [31:0] ADDR_ACK     = 32'(BASE_ADDRESS) + 32'h08;
   localparam logic [31:0] ADDR_TRIGGER = 32'(BASE_ADDRESS) + 32'h0C;
   localparam logic [31:0] ADDR_ACTIVE  = 32'(BASE_ADDRESS) + 32'h10;

   logic [N-1:0] sync1_q;
   logic [N-1:0] sync2_q;
   logic [N-1:0] prev_q;
   logic [N-1:0] pending_q;
   logic [N-1:0] pending_d;
   logic [N-1:0] mask_q;
   logic [N-1:0] trigger_q;
   logic         irq_q;
   logic [31:0]  read_data_q;
   logic [31:0]  read_data_d;

   logic [N-1:0] rise;
   logic [N-1:0] writeLines;
   logic         maskWr;
   logic         ackWr;
   logic         triggerWr;

   assign writeLines = write_data_i[N-1:0];
   assign rise       = sync2_q & ~prev_q;
   assign maskWr     = write_en_i && (address_i == ADDR_MASK);
   assign ackWr      = write_en_i && (address_i == ADDR_ACK);
   assign triggerWr  = write_en_i && (address_i == ADDR_TRIGGER);

   generate
      if (N < 32) begin : g_highBits
         logic unusedHighBits;
         assign unusedHighBits = ^write_data_i[31:N];
      end
   endgenerate

   function automatic logic [31:0] toWord(input logic [N-1:0] v);
      logic [31:0] w;
      w        = '0;
      w[N-1:0] = v;
      return w;
   endfunction

   // A fresh edge beats a simultaneous acknowledge so that no interrupt is lost.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < int'(N); i++) begin
         if (!trigger_q[i]) begin
            pending_d[i] = sync2_q[i];
         end else if (rise[i]) begin
            pending_d[i] = 1'b1;
         end else if (ackWr && writeLines[i]) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      read_data_d = '0;
      case (address_i)
         ADDR_PENDING: read_data_d = toWord(pending_q);
         ADDR_MASK:    read_data_d = toWord(mask_q);
         ADDR_TRIGGER: read_data_d = toWord(trigger_q);
         ADDR_ACTIVE:  read_data_d = toWord(pending_q & mask_q);
         default:      read_data_d = '0;
      endcase
   end

   // Reads sample the registers before any same-cycle write lands.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         prev_q      <= '0;
         pending_q   <= '0;
         mask_q      <= '0;
         trigger_q   <= '0;
         irq_q       <= 1'b0;
         read_data_q <= '0;
      end else begin
         sync1_q   <= irq_in_i;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         pending_q <= pending_d;
         irq_q     <= |(pending_q & mask_q);
         if (maskWr) begin
            mask_q <= writeLines;
         end
         if (triggerWr) begin
            trigger_q <= writeLines;
         end
         if (read_en_i) begin
            read_data_q <= read_data_d;
         end
      end
   end

   assign read_data_o = read_data_q;
   assign irq_out_o   = irq_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed stimulus pushes expected read data and
// interrupt levels into queues; a monitor pops and compares as the DUT presents them.
module tb_interrupt_controller;

   localparam logic [31:0] A_PENDING = 32'h00;
   localparam logic [31:0] A_MASK    = 32'h04;
   localparam logic [31:0] A_ACK     = 32'h08;
   localparam logic [31:0] A_TRIGGER = 32'h0C;
   localparam logic [31:0] A_ACTIVE  = 32'h10;
   localparam logic [31:0] A_UNMAP   = 32'h14;

   typedef struct {
      string       name;
      logic [31:0] value;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        writeEn, readEn, writeEn4, readEn4;
   logic [31:0] addr, wdata;
   logic [31:0] rdata, rdata4;
   logic [15:0] irqIn;
   logic        irqOut, irqOut4;

   logic        rdValid, rdValid4;
   logic        irqStrobe;

   exp_t rdQ[$];
   exp_t rd4Q[$];
   exp_t irqQ[$];

   int checks = 0;
   int errors = 0;

   interrupt_controller #(.BASE_ADDRESS(0), .NUM_INTERRUPTS(16)) dut (
      .clk_i(clk), .rst_ni(rstN), .write_en_i(writeEn), .read_en_i(readEn),
      .address_i(addr), .write_data_i(wdata), .read_data_o(rdata),
      .irq_in_i(irqIn), .irq_out_o(irqOut)
   );

   interrupt_controller #(.BASE_ADDRESS(0), .NUM_INTERRUPTS(4)) dut4 (
      .clk_i(clk), .rst_ni(rstN), .write_en_i(writeEn4), .read_en_i(readEn4),
      .address_i(addr), .write_data_i(wdata), .read_data_o(rdata4),
      .irq_in_i(irqIn[3:0]), .irq_out_o(irqOut4)
   );

   always #5 clk = ~clk;

   // Read data is valid the cycle after a read enable.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rdValid  <= 1'b0;
         rdValid4 <= 1'b0;
      end else begin
         rdValid  <= readEn;
         rdValid4 <= readEn4;
      end
   end

   task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor runs on the falling edge, well away from the sampling edge.
   always @(negedge clk) begin
      exp_t e;
      if (rdValid) begin
         if (rdQ.size() == 0) compare("unexpectedRead", rdata, 32'hDEAD_BEEF);
         else begin e = rdQ.pop_front(); compare(e.name, rdata, e.value); end
      end
      if (rdValid4) begin
         if (rd4Q.size() == 0) compare("unexpectedRead4", rdata4, 32'hDEAD_BEEF);
         else begin e = rd4Q.pop_front(); compare(e.name, rdata4, e.value); end
      end
      if (irqStrobe) begin
         if (irqQ.size() == 0) compare("unexpectedIrq", {31'b0, irqOut}, 32'hDEAD_BEEF);
         else begin e = irqQ.pop_front(); compare(e.name, {31'b0, irqOut}, e.value); end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
      writeEn = 1'b1; addr = a; wdata = d;
      cyc();
      writeEn = 1'b0;
   endtask

   task automatic checkOutput(input logic [31:0] a, input logic [31:0] exp, input string name);
      exp_t e;
      e.name = name; e.value = exp;
      rdQ.push_back(e);
      readEn = 1'b1; addr = a;
      cyc();
      readEn = 1'b0;
   endtask

   task automatic writeRead(input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp, input string name);
      exp_t e;
      e.name = name; e.value = exp;
      rdQ.push_back(e);
      writeEn = 1'b1; readEn = 1'b1; addr = a; wdata = d;
      cyc();
      writeEn = 1'b0; readEn = 1'b0;
   endtask

   task automatic write4(input logic [31:0] a, input logic [31:0] d);
      writeEn4 = 1'b1; addr = a; wdata = d;
      cyc();
      writeEn4 = 1'b0;
   endtask

   task automatic read4(input logic [31:0] a, input logic [31:0] exp, input string name);
      exp_t e;
      e.name = name; e.value = exp;
      rd4Q.push_back(e);
      readEn4 = 1'b1; addr = a;
      cyc();
      readEn4 = 1'b0;
   endtask

   // Samples the request as it stands after the most recent edge, then advances one edge.
   task automatic expectIrq(input logic v, input string name);
      exp_t e;
      e.name = name; e.value = {31'b0, v};
      irqQ.push_back(e);
      irqStrobe = 1'b1;
      cyc();
      irqStrobe = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rstN = 1'b0; writeEn = 1'b0; readEn = 1'b0; writeEn4 = 1'b0; readEn4 = 1'b0;
      addr = '0; wdata = '0; irqIn = '0; irqStrobe = 1'b0;
      repeat (2) cyc();
      rstN = 1'b1;
      cyc();

      // Reset values
      checkOutput(A_PENDING, 32'h0, "rstPending");
      checkOutput(A_MASK,    32'h0, "rstMask");
      checkOutput(A_ACK,     32'h0, "rstAck");
      checkOutput(A_TRIGGER, 32'h0, "rstTrigger");
      checkOutput(A_ACTIVE,  32'h0, "rstActive");
      checkOutput(A_UNMAP,   32'h0, "rstUnmapped");
      expectIrq(1'b0, "rstIrq");

      // Level line 0: four-edge assert and deassert latency, ACK ignored
      applyStimulus(A_MASK, 32'h1);
      irqIn[0] = 1'b1;
      repeat (3) cyc();
      expectIrq(1'b0, "levelRiseEdge3");
      expectIrq(1'b1, "levelRiseEdge4");
      irqIn[0] = 1'b0;
      repeat (3) cyc();
      expectIrq(1'b1, "levelFallEdge3");
      expectIrq(1'b0, "levelFallEdge4");
      irqIn[0] = 1'b1;
      repeat (4) cyc();
      expectIrq(1'b1, "levelHigh");
      applyStimulus(A_ACK, 32'h1);
      checkOutput(A_PENDING, 32'h1, "levelAckIgnored");
      expectIrq(1'b1, "levelAckIrq");
      irqIn[0] = 1'b0;
      repeat (5) cyc();

      // Edge line 1: pulse latches, ACK clears
      applyStimulus(A_TRIGGER, 32'h2);
      applyStimulus(A_MASK, 32'h2);
      irqIn[1] = 1'b1;
      cyc();
      irqIn[1] = 1'b0;
      repeat (4) cyc();
      checkOutput(A_PENDING, 32'h2, "edgePulsePending");
      expectIrq(1'b1, "edgePulseIrq");
      repeat (3) cyc();
      expectIrq(1'b1, "edgeHeldIrq");
      checkOutput(A_TRIGGER, 32'h2, "triggerReadback");
      checkOutput(A_ACK, 32'h0, "ackReadsZero");
      applyStimulus(A_ACK, 32'h2);
      expectIrq(1'b1, "ackIrqEdge1");
      expectIrq(1'b0, "ackIrqEdge2");
      checkOutput(A_PENDING, 32'h0, "ackPending");

      // Edge and ACK on the same edge: the edge wins; a held line does not re-trigger
      irqIn[1] = 1'b1;
      cyc();
      cyc();
      applyStimulus(A_ACK, 32'h2);
      checkOutput(A_PENDING, 32'h2, "edgeBeatsAck");
      applyStimulus(A_ACK, 32'h2);
      checkOutput(A_PENDING, 32'h0, "heldAckClears");
      repeat (3) cyc();
      checkOutput(A_PENDING, 32'h0, "heldNoRetrigger");
      irqIn[1] = 1'b0;
      repeat (4) cyc();

      // Masked pending line 3, then unmask
      applyStimulus(A_MASK, 32'h0);
      irqIn[3] = 1'b1;
      repeat (4) cyc();
      checkOutput(A_PENDING, 32'h8, "maskedPending");
      checkOutput(A_ACTIVE, 32'h0, "maskedActive");
      expectIrq(1'b0, "maskedIrq");
      applyStimulus(A_MASK, 32'h8);
      expectIrq(1'b0, "unmaskEdge1");
      expectIrq(1'b1, "unmaskEdge2");
      checkOutput(A_ACTIVE, 32'h8, "unmaskActive");
      writeRead(A_MASK, 32'h9, 32'h8, "writeReadOld");
      checkOutput(A_MASK, 32'h9, "writeReadNew");
      checkOutput(A_MASK, 32'h9, "preResetRead");
      cyc();

      // Asynchronous reset between clock edges
      #2 rstN = 1'b0;
      #1;
      compare("asyncRstIrq", {31'b0, irqOut}, 32'h0);
      compare("asyncRstRdata", rdata, 32'h0);
      irqIn = '0;
      repeat (2) cyc();
      #2 rstN = 1'b1;
      cyc();
      checkOutput(A_PENDING, 32'h0, "postRstPending");
      checkOutput(A_MASK,    32'h0, "postRstMask");
      checkOutput(A_TRIGGER, 32'h0, "postRstTrigger");
      checkOutput(A_ACTIVE,  32'h0, "postRstActive");
      expectIrq(1'b0, "postRstIrq");

      // Narrow instance: bits above the line count are dropped
      write4(A_MASK, 32'hFFFF_FFFF);
      read4(A_MASK, 32'hF, "narrowMask");
      write4(A_TRIGGER, 32'hFFFF_FFF5);
      read4(A_TRIGGER, 32'h5, "narrowTrigger");

      repeat (2) cyc();
      compare("queuesDrained", 32'(rdQ.size() + rd4Q.size() + irqQ.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
